// File: rtl/bp_pkg.sv
// ============================================================================
// Module : bp_pkg
// Brief  : Shared BP constants, reader state encoding and header helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int NUM_ENTRIES   = 64;
    localparam int DATA_W        = 64;
    localparam int TAG_W         = 2;
    localparam int ROUND_W       = 3;
    localparam int CNT_W         = 7;
    localparam int IDX_W         = 6;

    localparam int HDR_TAG_LSB   = 0;
    localparam int HDR_ROUND_LSB = 2;
    localparam int HDR_CNT_LSB   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_DONE   = 2'd3
    } rd_state_t;

    // CNT_W is 7 bits so a full mask (64) is representable.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] mask);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cnt = cnt + CNT_W'(mask[i]);
        end
        return cnt;
    endfunction

    function automatic logic [DATA_W-1:0] make_header(
        input logic [TAG_W-1:0]   tag,
        input logic [ROUND_W-1:0] round,
        input logic [CNT_W-1:0]   cnt
    );
        logic [DATA_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_TAG_LSB   +: TAG_W]   = tag;
        hdr[HDR_ROUND_LSB +: ROUND_W] = round;
        hdr[HDR_CNT_LSB   +: CNT_W]   = cnt;
        return hdr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_next_valid_finder.sv
// ============================================================================
// Module : bp_next_valid_finder
// Brief  : Combinational priority encoder: lowest set mask index >= i_start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_next_valid_finder
    import bp_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0] i_mask,
    input  logic [IDX_W:0]         i_start,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_found
);

    // i_start is one bit wider than an index so that 64 means "nothing left".
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (i_mask[i] && ((IDX_W+1)'(i) >= i_start)) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bp_outbuf_reader.sv
// ============================================================================
// Module : bp_outbuf_reader
// Brief  : Snapshots the BP output buffer on start and streams header + data.
//          Optional feature macro: BP_RD_SKIP_INVALID_EN (emit valid entries only).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_outbuf_reader
    import bp_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_rd_start,
    input  logic [NUM_ENTRIES-1:0]        io_rd_D_outBuf_valid,
    input  logic [NUM_ENTRIES*DATA_W-1:0] io_rd_D_outBuf_data,
    input  logic [TAG_W-1:0]              io_rd_Tag_outBuf_Tag,
    input  logic [ROUND_W-1:0]            io_rd_Tag_outBuf_RoundCnt,
    output logic                          io_out_valid,
    input  logic                          io_out_ready,
    output logic [DATA_W-1:0]             io_out_data,
    output logic [IDX_W-1:0]              io_out_idx,
    output logic                          io_out_isHeader,
    output logic                          io_out_last,
    output logic                          io_busy,
    output logic                          io_done
);

    rd_state_t                   r_state;
    rd_state_t                   w_next_state;

    logic [NUM_ENTRIES-1:0]        r_mask;
    logic [NUM_ENTRIES*DATA_W-1:0] r_data;
    logic [TAG_W-1:0]              r_tag;
    logic [ROUND_W-1:0]            r_round;
    logic [IDX_W-1:0]              r_idx;

    logic                          w_snap;
    logic [NUM_ENTRIES-1:0]        w_find_mask;
    logic [IDX_W:0]                w_find_start;
    logic [IDX_W-1:0]              w_next_idx;
    logic                          w_found;
    logic                          w_last;
    logic                          w_advance;

    assign w_snap = (r_state == ST_IDLE) && io_rd_start;

`ifdef BP_RD_SKIP_INVALID_EN
    assign w_find_mask = r_mask;
`else
    // Every entry is emitted, so the finder sees a fully populated mask.
    assign w_find_mask = '1;
`endif

    // From the header the search begins at entry 0; afterwards just past r_idx.
    assign w_find_start = (r_state == ST_HEADER) ? '0
                                                 : ({1'b0, r_idx} + (IDX_W+1)'(1));

    bp_next_valid_finder u_finder (
        .i_mask  (w_find_mask),
        .i_start (w_find_start),
        .o_idx   (w_next_idx),
        .o_found (w_found)
    );

    assign w_last    = !w_found;
    assign w_advance = ((r_state == ST_HEADER) || (r_state == ST_DATA)) && io_out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        io_out_valid    = 1'b0;
        io_out_data     = '0;
        io_out_idx      = '0;
        io_out_isHeader = 1'b0;
        io_out_last     = 1'b0;
        io_done         = 1'b0;
        io_busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (io_rd_start) begin
                    w_next_state = ST_HEADER;
                end
            end
            ST_HEADER: begin
                io_out_valid    = 1'b1;
                io_out_isHeader = 1'b1;
                io_out_data     = make_header(r_tag, r_round, popcount(r_mask));
                io_out_last     = w_last;
                if (io_out_ready) begin
                    w_next_state = w_last ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                io_out_valid = 1'b1;
                io_out_data  = r_data[int'(r_idx)*DATA_W +: DATA_W];
                io_out_idx   = r_idx;
                io_out_last  = w_last;
                if (io_out_ready && w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                io_done      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Index only ever loads finder results (0..63), so it cannot wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mask  <= '0;
            r_tag   <= '0;
            r_round <= '0;
            r_idx   <= '0;
        end else if (w_snap) begin
            r_mask  <= io_rd_D_outBuf_valid;
            r_tag   <= io_rd_Tag_outBuf_Tag;
            r_round <= io_rd_Tag_outBuf_RoundCnt;
            r_idx   <= '0;
        end else if (w_advance && !w_last) begin
            r_idx   <= w_next_idx;
        end
    end

    // Payload is only observable once a start has reloaded it.
    always_ff @(posedge clock) begin
        if (w_snap) begin
            r_data <= io_rd_D_outBuf_data;
        end
    end

endmodule

`default_nettype wire
